// File: rtl/spi_sclk_gen_pkg.sv
// spi_sclk_gen_pkg: shared state encoding, SPI mode constants and default widths
// Mode constants are {cpol, cpha}.
package spi_sclk_gen_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, FIN = ST_FIN} state_t;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
  localparam int DEF_DIV_W = 8;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/spi_sclk_div.sv
// spi_sclk_div: half-period divider with loadable target, wrap tick and stall hold
// Ports: clk, rstn (async active-low); clk_div_i/clk_div_valid_i load the target;
// en_i runs the counter (cleared when low); hold_i freezes it; tick_o marks a wrap.
module spi_sclk_div import spi_sclk_gen_pkg::*; #(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic             clk_div_valid_i,
  input  logic             en_i,
  input  logic             hold_i,
  output logic             tick_o
);
  logic [DIV_W-1:0] tgt_q, cnt_q, cnt_d;
  // Equality compare: lowering the target below the count wraps through 2^DIV_W.
  assign tick_o = en_i && !hold_i && cnt_q == tgt_q;
  assign cnt_d  = !en_i ? '0 : hold_i ? cnt_q : tick_o ? '0 : cnt_q + DIV_W'(1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      tgt_q <= '0;
      cnt_q <= '0;
    end else begin
      tgt_q <= clk_div_valid_i ? clk_div_i : tgt_q;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: N-bit SPI serial-clock generator with divider, CPOL/CPHA, strobes and abort
// Ports: clk, rstn (async active-low); clk_div/clk_div_valid program the half-period;
// cpol/cpha/num_bits are latched by start; abort cancels; busy/done handshake;
// sclk plus registered lead/trail/sample/shift strobes.
// Optional: SPI_SCLK_GEN_STALL_EN adds input stall, which holds timing before a lead edge.
module spi_sclk_gen import spi_sclk_gen_pkg::*; #(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             clk_div_valid,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             start,
  input  logic [CNT_W-1:0] num_bits,
  input  logic             abort,
`ifdef SPI_SCLK_GEN_STALL_EN
  input  logic             stall,
`endif
  output logic             busy,
  output logic             done,
  output logic             sclk,
  output logic             lead,
  output logic             trail,
  output logic             sample,
  output logic             shift
);
  state_t           state_q;
  logic             cpol_q, cpha_q, sclk_q, lead_q, trail_q, sample_q, shift_q;
  logic [CNT_W-1:0] nb_q, nb_e;
  logic [CNT_W:0]   ecnt_q, ecnt_e;
  logic             run, accept, last, en, hold, edg, cpha_e, is_lead, fin_edge;
  assign run    = state_q == RUN;
  assign accept = state_q == IDLE && start && num_bits != '0 && !abort;
  assign last   = run && ecnt_q == {nb_q, 1'b0};
  // The start cycle already counts toward the first half-period, so div=0 edges on acceptance.
  assign en     = accept || (run && !abort && !last);
`ifdef SPI_SCLK_GEN_STALL_EN
  assign hold   = stall && run && !ecnt_q[0];
`else
  assign hold   = 1'b0;
`endif
  // Settings seen by an edge in the acceptance cycle come straight from the inputs.
  assign cpha_e   = accept ? cpha : cpha_q;
  assign nb_e     = accept ? num_bits : nb_q;
  assign ecnt_e   = accept ? '0 : ecnt_q;
  assign is_lead  = !ecnt_e[0];
  assign fin_edge = ecnt_e + (CNT_W+1)'(1) == {nb_e, 1'b0};
  spi_sclk_div #(.DIV_W(DIV_W)) u_div (
    .clk             (clk),
    .rstn            (rstn),
    .clk_div_i       (clk_div),
    .clk_div_valid_i (clk_div_valid),
    .en_i            (en),
    .hold_i          (hold),
    .tick_o          (edg)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q  <= IDLE;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      nb_q     <= '0;
      ecnt_q   <= '0;
      sclk_q   <= 1'b0;
      lead_q   <= 1'b0;
      trail_q  <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
    end else begin
      lead_q   <= edg && is_lead;
      trail_q  <= edg && !is_lead;
      sample_q <= edg && (cpha_e ? !is_lead : is_lead);
      shift_q  <= edg && (cpha_e ? is_lead : !is_lead && !fin_edge);
      ecnt_q   <= edg ? ecnt_e + (CNT_W+1)'(1) : accept ? '0 : ecnt_q;
      case (state_q)
        IDLE: begin
          cpol_q <= cpol;
          sclk_q <= cpol ^ edg;
          if (accept) begin
            state_q <= RUN;
            cpha_q  <= cpha;
            nb_q    <= num_bits;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            sclk_q  <= cpol_q;
          end else if (last) state_q <= FIN;
          else if (edg) sclk_q <= !sclk_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign busy   = state_q == RUN;
  assign done   = state_q == FIN;
  assign sclk   = sclk_q;
  assign lead   = lead_q;
  assign trail  = trail_q;
  assign sample = sample_q;
  assign shift  = shift_q;
endmodule
